// File: rtl/stopwatch_ctrl.sv
// Mode controller for a 4-digit MM:SS stopwatch.
// Conditions the pause/sel/adj inputs and sequences RUN/PAUSED/ADJ_SEC/ADJ_MIN.
// Drives single-cycle increment enables, the carry enable and blink masks.
// All timing is derived from clock-enable ticks on clk; no divided clocks.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int RUN_DIV      = 100000000,
  parameter int ADJ_DIV      = 50000000,
  parameter int BLINK_DIV    = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause,
  input  logic       sel,
  input  logic       adj,
  output logic       inc_sec,
  output logic       inc_min,
  output logic       carry_en,
  output logic [3:0] blank,
  output logic [1:0] state
);

  localparam int DBW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int RW  = (RUN_DIV > 2)      ? $clog2(RUN_DIV)      : 1;
  localparam int AW  = (ADJ_DIV > 2)      ? $clog2(ADJ_DIV)      : 1;
  localparam int BW  = (BLINK_DIV > 2)    ? $clog2(BLINK_DIV)    : 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_PAUSED  = 2'b01,
    ST_ADJ_SEC = 2'b10,
    ST_ADJ_MIN = 2'b11
  } state_t;

  // Raw inputs packed so the conditioning chain can be replicated: 0 pause, 1 sel, 2 adj.
  logic [2:0] raw_in;
  logic [2:0] db_level;
  logic       pause_rise;

  assign raw_in = {adj, sel, pause};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cond
      logic           sync1_q, sync2_q;
      logic           level_q, level_d;
      logic [DBW-1:0] cnt_q, cnt_d;

      // Debounce: count consecutive mismatched cycles, adopt the synced value at the limit.
      always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
          if (cnt_q == DBW'(DEBOUNCE_CYC - 1)) begin
            level_d = sync2_q;
          end else begin
            cnt_d = cnt_q + DBW'(1);
          end
        end
      end

      // Two-flop synchronizer plus debounce state.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
          level_q <= 1'b0;
          cnt_q   <= '0;
        end else begin
          sync1_q <= raw_in[gi];
          sync2_q <= sync1_q;
          level_q <= level_d;
          cnt_q   <= cnt_d;
        end
      end

      assign db_level[gi] = level_q;

      // Only the pause button needs an edge detector.
      if (gi == 0) begin : g_rise
        assign pause_rise = level_d & ~level_q;
      end
    end
  endgenerate

  logic db_sel, db_adj;
  assign db_sel = db_level[1];
  assign db_adj = db_level[2];

  state_t          state_q, state_d;
  logic            press_q;
  logic [RW-1:0]   run_cnt_q, run_cnt_d;
  logic [AW-1:0]   adj_cnt_q, adj_cnt_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_phase_q, blink_phase_d;
  logic            run_tick, adj_tick, blink_tick;
  logic            in_adj, adj_entry;
  logic            inc_sec_q, inc_sec_d;
  logic            inc_min_q, inc_min_d;
  logic            carry_en_q, carry_en_d;
  logic [3:0]      blank_q, blank_d;

  // Next-state logic: adjust mode overrides everything, pause presses only act in RUN/PAUSED.
  always_comb begin
    state_d = state_q;
    if (db_adj) begin
      state_d = db_sel ? ST_ADJ_MIN : ST_ADJ_SEC;
    end else begin
      case (state_q)
        ST_RUN:     if (press_q) state_d = ST_PAUSED;
        ST_PAUSED:  if (press_q) state_d = ST_RUN;
        default:    state_d = ST_PAUSED;
      endcase
    end
  end

  assign in_adj     = state_q[1];
  assign adj_entry  = state_d[1] && (state_d != state_q);
  assign run_tick   = (state_q == ST_RUN) && (run_cnt_q == RW'(RUN_DIV - 1));
  assign adj_tick   = in_adj && (adj_cnt_q == AW'(ADJ_DIV - 1));
  assign blink_tick = (blink_cnt_q == BW'(BLINK_DIV - 1));

  // Prescalers: run count freezes outside RUN so a partial second survives a pause.
  always_comb begin
    run_cnt_d     = run_cnt_q;
    adj_cnt_d     = adj_cnt_q;
    blink_cnt_d   = blink_tick ? '0 : blink_cnt_q + BW'(1);
    blink_phase_d = blink_phase_q ^ blink_tick;
    if (state_q == ST_RUN) begin
      run_cnt_d = run_tick ? '0 : run_cnt_q + RW'(1);
    end
    if (adj_entry) begin
      adj_cnt_d = '0;
    end else if (in_adj) begin
      adj_cnt_d = adj_tick ? '0 : adj_cnt_q + AW'(1);
    end
  end

  // Output decode, registered one cycle behind the state/tick that causes it.
  always_comb begin
    inc_sec_d  = ((state_q == ST_RUN) && run_tick) || ((state_q == ST_ADJ_SEC) && adj_tick);
    inc_min_d  = (state_q == ST_ADJ_MIN) && adj_tick;
    carry_en_d = (state_q == ST_RUN);
    blank_d    = 4'b0000;
    if (state_q == ST_ADJ_SEC) begin
      blank_d = {2'b00, {2{blink_phase_q}}};
    end else if (state_q == ST_ADJ_MIN) begin
      blank_d = {{2{blink_phase_q}}, 2'b00};
    end
  end

  // State, prescaler and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_PAUSED;
      press_q       <= 1'b0;
      run_cnt_q     <= '0;
      adj_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      inc_sec_q     <= 1'b0;
      inc_min_q     <= 1'b0;
      carry_en_q    <= 1'b0;
      blank_q       <= 4'b0000;
    end else begin
      state_q       <= state_d;
      press_q       <= pause_rise;
      run_cnt_q     <= run_cnt_d;
      adj_cnt_q     <= adj_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      inc_sec_q     <= inc_sec_d;
      inc_min_q     <= inc_min_d;
      carry_en_q    <= carry_en_d;
      blank_q       <= blank_d;
    end
  end

  assign inc_sec  = inc_sec_q;
  assign inc_min  = inc_min_q;
  assign carry_en = carry_en_q;
  assign blank    = blank_q;
  assign state    = state_q;

endmodule
